// File: rtl/ulv_shift_reg_pkg.sv
// Shared types and defaults for the ulv_shift_reg universal shift register.
// Operation codes are exposed as an enum so callers and the bench can name them.
package ulv_shift_reg_pkg;

  localparam int ULV_SHIFT_REG_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    CTRL_HOLD = 2'b00,
    CTRL_SHL  = 2'b01,
    CTRL_SHR  = 2'b10,
    CTRL_LOAD = 2'b11
  } ctrl_e;

endpackage

// File: rtl/ulv_shift_reg_next.sv
// Combinational next-state selector for ulv_shift_reg.
// Serial-in bits are taken from the parallel input so one data bus serves load and shift.
module ulv_shift_reg_next
  import ulv_shift_reg_pkg::*;
#(
  parameter int N = ULV_SHIFT_REG_N_DEFAULT
) (
  input  logic [N-1:0] q,
  input  logic [N-1:0] d,
  input  logic [1:0]   ctrl,
  output logic [N-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (ctrl_e'(ctrl))
      CTRL_HOLD: q_next = q;
      CTRL_SHL:  q_next = {q[N-2:0], d[0]};
      CTRL_SHR:  q_next = {d[N-1], q[N-1:1]};
      CTRL_LOAD: q_next = d;
    endcase
  end

endmodule

// File: rtl/ulv_shift_reg.sv
// N-bit universal shift register (hold / shift left / shift right / load), async reset.
// Define ULV_SHIFT_REG_SERIAL_OUT_EN to add the so_l / so_r serial-out ports.
module ulv_shift_reg
  import ulv_shift_reg_pkg::*;
#(
  parameter int N = ULV_SHIFT_REG_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   ctrl,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
`ifdef ULV_SHIFT_REG_SERIAL_OUT_EN
  ,
  output logic         so_l,
  output logic         so_r
`endif
);

  logic [N-1:0] q_p0;
  logic [N-1:0] q_next;

  ulv_shift_reg_next #(.N(N)) u_next (
    .q      (q_p0),
    .d      (d),
    .ctrl   (ctrl),
    .q_next (q_next)
  );

  // Stage p0: the only state; reset clears it without waiting for a clock edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_p0 <= '0;
    end else begin
      q_p0 <= q_next;
    end
  end

  assign q = q_p0;

`ifdef ULV_SHIFT_REG_SERIAL_OUT_EN
  assign so_l = q_p0[N-1];
  assign so_r = q_p0[0];
`endif

endmodule

// File: tb/tb_ulv_shift_reg.sv
// Scoreboard bench for ulv_shift_reg: stimulus pushes expected q, a monitor pops after each edge.
// Reference model uses plain integer arithmetic on the register value.
module tb_ulv_shift_reg;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   ctrl;
  logic [N-1:0] d;
  logic [N-1:0] q;
`ifdef ULV_SHIFT_REG_SERIAL_OUT_EN
  logic         so_l;
  logic         so_r;
`endif

  int checks = 0;
  int errors = 0;
  int model_q = 0;
  int exp_q[$];

  ulv_shift_reg #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (ctrl),
    .d     (d),
    .q     (q)
`ifdef ULV_SHIFT_REG_SERIAL_OUT_EN
    ,
    .so_l  (so_l),
    .so_r  (so_r)
`endif
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_next(input int cur, input int c, input int dv);
    case (c)
      0:       return cur;
      1:       return (cur * 2 + (dv % 2)) % 256;
      2:       return cur / 2 + ((dv / 128) % 2) * 128;
      default: return dv;
    endcase
  endfunction

  // Called at a negedge: drive inputs, record expectation, move to the next negedge.
  // exp_lit >= 0 also pins the expected value to a hand-derived constant.
  task automatic step(input int c, input int dv, input int exp_lit);
    ctrl = c[1:0];
    d    = dv[N-1:0];
    model_q = ref_next(model_q, c, dv);
    if (exp_lit >= 0) begin
      exp_q.push_back(exp_lit);
      model_q = exp_lit;
    end else begin
      exp_q.push_back(model_q);
    end
    @(negedge clk);
  endtask

  // Called at a negedge: assert reset between edges, check q clears at once, release at negedge.
  task automatic mid_reset(input string tag);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check({tag, "_async_clear"}, int'(q), 0);
    @(negedge clk);
    check({tag, "_held_zero"}, int'(q), 0);
    reset = 1'b0;
    model_q = 0;
  endtask

  // Monitor: one registered result per rising edge
  initial begin
    int e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("q", int'(q), e);
`ifdef ULV_SHIFT_REG_SERIAL_OUT_EN
        check("so_l", int'(so_l), (e / 128) % 2);
        check("so_r", int'(so_r), e % 2);
`endif
      end
    end
  end

  initial begin
    int c;
    int dv;
    reset = 1'b1;
    ctrl  = 2'b11;
    d     = 8'h05;
    #5;
    check("reset_initial", int'(q), 0);
    #10;
    check("reset_over_edge", int'(q), 0);
    @(negedge clk);
    reset = 1'b0;

    // Load after reset release
    step(3, 8'h05, 8'h05);
    // Hold while d changes
    for (int i = 5; i <= 10; i++) step(0, i, 8'h05);
    // Load then shift left with d[0] entering the LSB
    step(3, 8'h0A, 8'h0A);
    step(1, 8'h0A, 8'h14);
    step(1, 8'h0B, 8'h29);
    step(3, 8'hC0, 8'hC0);
    step(1, 8'h00, 8'h80);
    // Shift right with d[7] entering the MSB
    step(3, 8'h81, 8'h81);
    step(2, 8'h80, 8'hC0);
    step(2, 8'h00, 8'h60);
    // Serial-out view of 0x81 then SHL with d[0]=0
    step(3, 8'h81, 8'h81);
    step(1, 8'h00, 8'h02);
    // Async reset mid-shift, then load
    step(1, 8'h01, 8'h05);
    mid_reset("midshift");
    step(3, 8'hA5, 8'hA5);

    // Randomized operations with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        mid_reset("rand");
      end
      c  = int'($urandom_range(0, 3));
      dv = int'($urandom_range(0, 255));
      step(c, dv, -1);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
